mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one generic 2:1 Mux datapath between two requesters.

---
 rtl/mux_rr_arbiter_if.sv | 44 ++++
 rtl/mux_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between two producers, the round-robin arbiter and one consumer.
// The master side drives requests/data/ready; the slave side (the arbiter) drives grants and output.
interface mux_rr_arbiter_if #(
    parameter int unsigned width = 2
) ();

    logic             req0;
    logic             req1;
    logic [width-1:0] in0;
    logic [width-1:0] in1;
    logic             out_ready;
    logic             gnt0;
    logic             gnt1;
    logic             select;
    logic             out_valid;
    logic [width-1:0] out_data;

    modport master (
        output req0,
        output req1,
        output in0,
        output in1,
        output out_ready,
        input  gnt0,
        input  gnt1,
        input  select,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  req0,
        input  req1,
        input  in0,
        input  in1,
        input  out_ready,
        output gnt0,
        output gnt1,
        output select,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between two valid/ready producers, with a per-grant
// beat budget that forces a hand-over when the other port is waiting.
module mux_rr_arbiter #(
    parameter int unsigned width    = 2,
    parameter int unsigned max_hold = 4
) (
    input logic             clk,
    input logic             reset,
    mux_rr_arbiter_if.slave bus
);

    localparam int unsigned cnt_w = $clog2(max_hold) + 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(max_hold - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic             last_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             select_q;

    logic             req_own;
    logic             req_oth;
    state_e           oth_st;
    logic             out_valid;
    logic             beat;
    logic [width-1:0] mux_out;

    // Owner-relative view of the requests so both OWN states share one transition rule.
    always_comb begin
        req_own = 1'b0;
        req_oth = 1'b0;
        oth_st  = StIdle;
        unique case (state_q)
            StOwn0: begin
                req_own = bus.req0;
                req_oth = bus.req1;
                oth_st  = StOwn1;
            end
            StOwn1: begin
                req_own = bus.req1;
                req_oth = bus.req0;
                oth_st  = StOwn0;
            end
            default: begin
                req_own = 1'b0;
                req_oth = 1'b0;
                oth_st  = StIdle;
            end
        endcase
    end

    assign out_valid = ((state_q == StOwn0) & bus.req0) | ((state_q == StOwn1) & bus.req1);
    assign beat      = out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                // last_q == 1 means port 1 owned last, so port 0 wins a tie.
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (bus.req0) begin
                    state_d = StOwn0;
                end else if (bus.req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (!req_own) begin
                    cnt_d   = '0;
                    state_d = req_oth ? oth_st : StIdle;
                end else if (beat) begin
                    if (cnt_q == cnt_last) begin
                        cnt_d = '0;
                        if (req_oth) begin
                            state_d = oth_st;
                        end
                    end else begin
                        cnt_d = cnt_q + cnt_w'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            select_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= (state_d == StOwn0);
            gnt1_q  <= (state_d == StOwn1);
            // select and last owner only move when a port owns the channel; IDLE holds them.
            if (state_d != StIdle) begin
                select_q <= (state_d == StOwn1);
                last_q   <= (state_d == StOwn1);
            end
        end
    end

    always_comb begin
        mux_out = bus.in0;
        if (select_q) begin
            mux_out = bus.in1;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.select    = select_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mux_out;

    a_gnt_onehot : assert property (@(posedge clk) disable iff (reset) !(gnt0_q && gnt1_q));
    a_sel_own1 : assert property (@(posedge clk) disable iff (reset)
        (state_q == StOwn1) |-> select_q);
    a_sel_own0 : assert property (@(posedge clk) disable iff (reset)
        (state_q == StOwn0) |-> !select_q);
    a_cnt_range : assert property (@(posedge clk) disable iff (reset) cnt_q <= cnt_last);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: stimulus pushes expected per-cycle outputs and beats,
// a negedge monitor pops and compares them against the DUT.
module tb_mux_rr_arbiter;

    localparam int unsigned W    = 2;
    localparam int unsigned MAXH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.width(W)) bus ();

    mux_rr_arbiter #(
        .width   (W),
        .max_hold(MAXH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] cyc_q[$];  // {gnt0, gnt1, select, out_valid}
    logic [W:0] beat_q[$]; // {port, data}
    bit         mon_en = 1'b0;

    // Reference model: owner -1 = idle, beats served in current grant, last owner, select.
    int   m_owner;
    int   m_beats;
    int   m_last;
    logic m_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = 1;
        m_sel   = 1'b0;
    endfunction

    function automatic void model_step(input bit r0, input bit r1, input bit rdy);
        bit req[2];
        int x;
        req[0] = r0;
        req[1] = r1;
        if (m_owner < 0) begin
            if (r0 && r1) m_owner = 1 - m_last;
            else if (r0) m_owner = 0;
            else if (r1) m_owner = 1;
            m_beats = 0;
        end else begin
            x = m_owner;
            if (!req[x]) begin
                m_owner = req[1-x] ? 1 - x : -1;
                m_beats = 0;
            end else if (rdy) begin
                m_beats++;
                if (m_beats == MAXH) begin
                    m_beats = 0;
                    if (req[1-x]) m_owner = 1 - x;
                end
            end
        end
        if (m_owner >= 0) begin
            m_last = m_owner;
            m_sel  = (m_owner == 1);
        end
    endfunction

    task automatic cycle(input bit rst, input bit r0, input bit r1, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input bit rdy, output bit b0, output bit b1);
        bit g0, g1, v;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.req0      = r0;
        bus.req1      = r1;
        bus.in0       = d0;
        bus.in1       = d1;
        bus.out_ready = rdy;
        if (rst) model_reset();
        g0 = (m_owner == 0);
        g1 = (m_owner == 1);
        v  = (g0 && r0) || (g1 && r1);
        cyc_q.push_back({g0, g1, m_sel, v});
        b0 = g0 && v && rdy;
        b1 = g1 && v && rdy;
        if (v && rdy) beat_q.push_back({g1, g1 ? d1 : d0});
        if (!rst) model_step(r0, r1, rdy);
        mon_en = 1'b1;
    endtask

    task automatic c(input bit r0, input bit r1, input logic [W-1:0] d0, input logic [W-1:0] d1,
                     input bit rdy);
        bit b0, b1;
        cycle(1'b0, r0, r1, d0, d1, rdy, b0, b1);
    endtask

    task automatic rst_cycle();
        bit b0, b1;
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, b0, b1);
    endtask

    // Reset raised between edges must clear outputs before the next rising edge.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {bus.gnt0, bus.gnt1, bus.select, bus.out_valid}, 4'b0000);
        model_reset();
    endtask

    always @(negedge clk) begin
        logic [3:0] e;
        logic [W:0] b;
        if (mon_en) begin
            if (cyc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cyc_underflow: no expected entry at %0t", $time);
            end else begin
                e = cyc_q.pop_front();
                check("gnt0_gnt1_select_valid", {bus.gnt0, bus.gnt1, bus.select, bus.out_valid}, e);
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h, expected none at %0t",
                             bus.out_data, $time);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_port_data", {bus.select, bus.out_data}, b);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit         p0, p1, b0, b1, rdy;
        logic [W-1:0] x0, x1;
        int         rate;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.in0       = '0;
        bus.in1       = '0;
        bus.out_ready = 1'b0;
        model_reset();

        rst_cycle();
        rst_cycle();

        // Single request from idle, then reset while owning.
        c(1, 0, 2'b10, 2'b00, 1);
        c(1, 0, 2'b10, 2'b00, 1);
        mid_reset();
        rst_cycle();

        // Tie after reset goes to port 0; dropping req0 hands over with no idle cycle.
        c(1, 1, 2'b01, 2'b10, 1);
        c(1, 1, 2'b01, 2'b10, 1);
        c(0, 1, 2'b01, 2'b10, 1);
        c(0, 1, 2'b01, 2'b10, 1);
        c(0, 0, 2'b00, 2'b00, 1);
        c(0, 0, 2'b00, 2'b00, 1);

        // Both held: alternating bursts of MAXH beats.
        repeat (20) c(1, 1, 2'b01, 2'b10, 1);
        c(0, 0, 2'b00, 2'b00, 1);
        c(0, 0, 2'b00, 2'b00, 1);

        // Two beats, long stall, then exactly two more before hand-over.
        c(1, 0, 2'b11, 2'b01, 1);
        c(1, 0, 2'b11, 2'b01, 1);
        c(1, 0, 2'b11, 2'b01, 1);
        repeat (10) c(1, 1, 2'b11, 2'b01, 0);
        repeat (4) c(1, 1, 2'b11, 2'b01, 1);
        c(0, 0, 2'b00, 2'b00, 1);
        c(0, 0, 2'b00, 2'b00, 1);

        // Lone requester keeps the grant across counter wraps; reset clears select at once.
        repeat (11) c(0, 1, 2'b00, 2'b10, 1);
        mid_reset();
        rst_cycle();

        p0 = 1'b0;
        p1 = 1'b0;
        x0 = '0;
        x1 = '0;
        rate = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rate = $urandom_range(10, 95);
            if (i % 700 == 699) begin
                mid_reset();
                rst_cycle();
                p0 = 1'b0;
                p1 = 1'b0;
            end
            if (!p0 && $urandom_range(0, 99) < rate) begin
                p0 = 1'b1;
                x0 = W'($urandom);
            end
            if (!p1 && $urandom_range(0, 99) < rate) begin
                p1 = 1'b1;
                x1 = W'($urandom);
            end
            rdy = ($urandom_range(0, 99) < 75);
            cycle(1'b0, p0, p1, x0, x1, rdy, b0, b1);
            if (b0) p0 = 1'b0;
            if (b1) p1 = 1'b0;
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("queue_drain", cyc_q.size() + beat_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
